// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle RV32I load/store unit that sits between the pipeline and a
// word-organised data memory. The pipeline issues one access at a time. The
// unit handles the following steps:
//   - checks the access for alignment and encoding faults,
//   - performs word loads and stores directly,
//   - implements byte and half-word stores as a read-modify-write of the
//     containing word,
//   - returns sign- or zero-extended load data in a register.
//
// Ports
//   clk        single clock, rising-edge state updates
//   rst        asynchronous active-high reset
//   req        access request, sampled only while ready=1
//   we         1 = store, 0 = load
//   funct3     RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       byte address
//   wdata      store data, right-aligned
//   ready      unit idle; a request is accepted on this edge
//   done       one-cycle completion pulse
//   rdata      registered load result (cleared on a fault)
//   misalign   one-cycle fault pulse, coincident with done
//   mem_addr   word index to the data memory
//   mem_wdata  full word to the data memory
//   mem_wr_en  data memory write strobe (memory writes on the falling edge)
//   mem_rd_en  data memory read enable
//   mem_rdata  combinational read data from the data memory
// ---------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP,
        FAULT
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    // Holds the store data. After RMW_RD it holds the merged word instead.
    logic [31:0] data_q;

    logic        fault;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Fault check runs on the live request inputs, so a bad access goes
    // straight from IDLE to FAULT without touching memory.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        fault = 1'b0;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr[0];
            F3_W:    fault = (addr[1:0] != 2'b00);
            F3_BU:   fault = we;                 // there is no unsigned store
            F3_HU:   fault = we | addr[0];
            default: fault = 1'b1;               // encodings 011, 110, 111
        endcase
    end

    // Little-endian lane extraction of the word currently on mem_rdata.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        case (funct3_q)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane.
    // funct3_q[0] tells SB (0) apart from SH (1). SBU/SHU never reach here.
    always_comb begin
        merged = mem_rdata;
        if (!funct3_q[0]) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            rdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        funct3_q <= funct3;
                        addr_q   <= addr;
                        data_q   <= wdata;
                        if (fault) begin
                            // Clear now so rdata already reads 0 during
                            // the fault pulse.
                            rdata <= 32'h0;
                            state <= FAULT;
                        end else if (!we) begin
                            state <= LOAD;
                        end else if (funct3 == F3_W) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata <= load_val;
                    state <= RESP;
                end
                RMW_RD: begin
                    data_q <= merged;
                    state  <= WRITE;
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The handshake and memory outputs are decoded straight from the state
    // register. This lets an asynchronous reset drop every strobe at once,
    // without waiting for a clock edge.
    always_comb begin
        ready     = (state == IDLE);
        done      = (state == RESP) || (state == FAULT);
        misalign  = (state == FAULT);
        mem_rd_en = (state == LOAD) || (state == RMW_RD);
        mem_wr_en = (state == WRITE);
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (mem_rd_en || mem_wr_en) begin
            mem_addr = {2'b00, addr_q[31:2]};
        end
        if (mem_wr_en) begin
            mem_wdata = data_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A 16-word data memory model reads
// combinationally and writes on the falling edge. Each access is timed from
// its accepting edge to its done cycle. Memory strobes are counted along the
// way, and the results are compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    assign mem_rdata = mem[mem_addr[3:0]];

    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the most recent access.
    int          lat;
    int          rd_cnt;
    int          wr_cnt;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic [31:0] rd_at_done;
    logic        mis_at_done;

    // Issue one access and watch it until done (at most 8 cycles).
    task automatic access(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        check({tag, ".ready"}, ready, 1);
        check({tag, ".idle_done"}, done, 0);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rd_cnt = 0; wr_cnt = 0; wr_data = 0; wr_addr = 0;
        rd_at_done = 0; mis_at_done = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) begin
                wr_cnt++;
                wr_data = mem_wdata;
                wr_addr = mem_addr;
            end
            if (done) begin
                lat         = c;
                mis_at_done = misalign;
                rd_at_done  = rdata;
                break;
            end
        end
    endtask

    task automatic expect_res(input string tag, input int e_lat, input int e_rd,
                              input int e_wr, input logic e_mis);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".rd_en_cycles"}, rd_cnt, e_rd);
        check({tag, ".wr_en_cycles"}, wr_cnt, e_wr);
        check({tag, ".misalign"}, mis_at_done, e_mis);
    endtask

    logic [6:0]  ready_v, done_v, rd_v, wr_v;
    int          overlap;
    int          rst_wr, rst_done;
    logic [31:0] b2b_rdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1; req = 1'b1; we = 1'b1; funct3 = 3'b010;
        addr = 32'h4; wdata = 32'h55;

        // Reset state, with a request pending that must be ignored.
        repeat (3) @(negedge clk);
        check("rst.ready", ready, 1);
        check("rst.done", done, 0);
        check("rst.misalign", misalign, 0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.wr_en", mem_wr_en, 0);
        check("rst.rd_en", mem_rd_en, 0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        req = 1'b0;
        rst = 1'b0;

        // SW 0x08
        access("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        expect_res("sw08", 2, 0, 1, 1'b0);
        check("sw08.mem_addr", wr_addr, 32'h2);
        check("sw08.mem_wdata", wr_data, 32'hDEADBEEF);

        // LW 0x08
        access("lw08", 1'b0, 3'b010, 32'h08, 32'h0);
        expect_res("lw08", 2, 1, 0, 1'b0);
        check("lw08.rdata", rd_at_done, 32'hDEADBEEF);

        // SB 0x09: read-modify-write
        access("sb09", 1'b1, 3'b000, 32'h09, 32'h000000A5);
        expect_res("sb09", 3, 1, 1, 1'b0);
        check("sb09.mem_addr", wr_addr, 32'h2);
        check("sb09.mem_wdata", wr_data, 32'hDEADA5EF);

        access("lb09", 1'b0, 3'b000, 32'h09, 32'h0);
        check("lb09.rdata", rd_at_done, 32'hFFFFFFA5);
        access("lbu09", 1'b0, 3'b100, 32'h09, 32'h0);
        check("lbu09.rdata", rd_at_done, 32'h000000A5);

        // SH 0x0A. rdata must still hold the LBU result during the store.
        access("sh0a", 1'b1, 3'b001, 32'h0A, 32'h00001234);
        expect_res("sh0a", 3, 1, 1, 1'b0);
        check("sh0a.mem_wdata", wr_data, 32'h1234A5EF);
        check("sh0a.rdata_hold", rd_at_done, 32'h000000A5);

        access("lh0a", 1'b0, 3'b001, 32'h0A, 32'h0);
        check("lh0a.rdata", rd_at_done, 32'h00001234);
        access("lh08", 1'b0, 3'b001, 32'h08, 32'h0);
        check("lh08.rdata", rd_at_done, 32'hFFFFA5EF);
        access("lhu08", 1'b0, 3'b101, 32'h08, 32'h0);
        check("lhu08.rdata", rd_at_done, 32'h0000A5EF);

        // Faults
        access("lh0b", 1'b0, 3'b001, 32'h0B, 32'h0);
        expect_res("lh0b", 1, 0, 0, 1'b1);
        @(negedge clk);
        check("lh0b.rdata_after", rdata, 32'h0);

        access("lw08b", 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw08b.rdata", rd_at_done, 32'h1234A5EF);
        access("lw06", 1'b0, 3'b010, 32'h06, 32'h0);
        expect_res("lw06", 1, 0, 0, 1'b1);
        @(negedge clk);
        check("lw06.rdata_after", rdata, 32'h0);

        access("f3_011", 1'b0, 3'b011, 32'h08, 32'h0);
        expect_res("f3_011", 1, 0, 0, 1'b1);
        access("shu", 1'b1, 3'b101, 32'h08, 32'hFFFF);
        expect_res("shu", 1, 0, 0, 1'b1);

        // Reset in the middle of RMW_RD of SB 0x09
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h09; wdata = 32'h11;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("mid_rst.rd_en_before", mem_rd_en, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst.rd_en", mem_rd_en, 0);
        check("mid_rst.mem_addr", mem_addr, 32'h0);
        check("mid_rst.ready", ready, 1);
        check("mid_rst.rdata", rdata, 32'h0);
        rst_wr = 0; rst_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wr_en) rst_wr++;
            if (done) rst_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_wr_en) rst_wr++;
            if (done) rst_done++;
        end
        check("mid_rst.wr_en_cycles", rst_wr, 0);
        check("mid_rst.done_cycles", rst_done, 0);
        access("lw_after_rst", 1'b0, 3'b010, 32'h08, 32'h0);
        expect_res("lw_after_rst", 2, 1, 0, 1'b0);
        check("lw_after_rst.rdata", rd_at_done, 32'h1234A5EF);

        // req held high for 6 cycles: SW 0x0C, then LW 0x0C
        overlap = 0; b2b_rdata = 0;
        ready_v = 0; done_v = 0; rd_v = 0; wr_v = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0C; wdata = 32'hCAFEF00D;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            ready_v[i] = ready;
            done_v[i]  = done;
            rd_v[i]    = mem_rd_en;
            wr_v[i]    = mem_wr_en;
            if (mem_rd_en && mem_wr_en) overlap++;
            if (i == 5) b2b_rdata = rdata;
            if (i == 2) we = 1'b0;
            if (i == 6) req = 1'b0;
        end
        check("b2b.ready_pattern", ready_v, 7'b1001001);
        check("b2b.done_pattern", done_v, 7'b0100100);
        check("b2b.rd_en_pattern", rd_v, 7'b0010000);
        check("b2b.wr_en_pattern", wr_v, 7'b0000010);
        check("b2b.overlap", overlap, 0);
        check("b2b.rdata", b2b_rdata, 32'hCAFEF00D);
        @(negedge clk);
        check("b2b.no_third_accept", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req  input  1  access request from pipeline; sampled only when ready=1.
REQ-004 we  input  1  1=store, 0=load.
REQ-005 funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 addr  input  32  byte address.
REQ-007 wdata  input  32  store data, right-aligned.
REQ-008 ready  output  1  unit idle, request accepted on this edge.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  registered load result.
REQ-011 misalign  output  1  one-cycle fault pulse, coincident with done.
REQ-012 mem_addr  output  32  word index to data memory, {2'b0, addr[31:2]}.
REQ-013 mem_wdata  output  32  full word to data memory.
REQ-014 mem_wr_en  output  1  data memory write strobe (memory writes on falling edge).
REQ-015 mem_rd_en  output  1  data memory read enable.
REQ-016 mem_rdata  input  32  combinational read data from data memory.

Function
REQ-017 States: IDLE, LOAD, RMW_RD, WRITE, RESP, FAULT; ready=1 only in IDLE.
REQ-018 Accept on rising edge with req=1 and state IDLE; latch we, funct3, addr, wdata.
REQ-019 Fault conditions: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
REQ-020 Fault path: IDLE->FAULT->IDLE; FAULT drives done=1, misalign=1, rdata<=0; no mem_rd_en or mem_wr_en.
REQ-021 Load path: IDLE->LOAD->RESP->IDLE; in LOAD mem_rd_en=1, mem_addr=word index; rdata registered at end of LOAD.
REQ-022 Load extraction, little-endian: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-023 Word store: IDLE->WRITE->RESP->IDLE; in WRITE mem_wr_en=1, mem_wdata=wdata.
REQ-024 Byte/half store, read-modify-write: IDLE->RMW_RD->WRITE->RESP->IDLE.
REQ-025 RMW_RD: mem_rd_en=1; register mem_rdata with the selected lane replaced by wdata[7:0] or wdata[15:0].
REQ-026 RMW WRITE: mem_wr_en=1 with the merged word; other lanes are unchanged.
REQ-027 RESP: done=1 for exactly one cycle, misalign=0; next state IDLE.
REQ-028 Latency from accepting edge to done cycle: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, fault 1 cycle.
REQ-029 mem_wr_en is high only in WRITE and mem_rd_en only in LOAD/RMW_RD, each for exactly one cycle per access.
REQ-030 Outside LOAD/RMW_RD/WRITE, mem_addr=0 and mem_wdata=0.
REQ-031 rdata holds its last value across stores and idle cycles; it changes only on load completion or fault.
REQ-032 req held high across consecutive cycles: the next request is accepted only on the first edge back in IDLE, after the done cycle.

Reset
REQ-033 While rst=1: state=IDLE, rdata=0, done=0, misalign=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0, ready=1, req ignored.
REQ-034 rst asserted mid-operation drops all memory strobes immediately, combinationally from the reset state, and abandons the access with no done pulse.

Verification
REQ-035 Reset, SW addr 0x08 wdata 0xDEADBEEF -> one cycle mem_wr_en=1, mem_addr=0x2, mem_wdata=0xDEADBEEF; done 2 cycles after accept; then LW 0x08 -> rdata=0xDEADBEEF.
REQ-036 After REQ-035, SB addr 0x09 wdata 0x000000A5 -> mem_rd_en cycle, then write 0xDEADA5EF, done at 3 cycles; LB 0x09 -> 0xFFFFFFA5; LBU 0x09 -> 0x000000A5.
REQ-037 SH addr 0x0A wdata 0x00001234 -> word 0x1234A5EF; LH 0x0A -> 0x00001234; LH 0x0B -> misalign=1, done=1, rdata=0, no memory strobe.
REQ-038 LW addr 0x06 and funct3=011 loads -> fault in 1 cycle, rdata=0.
REQ-039 rst pulsed during RMW_RD of SB 0x09 -> no mem_wr_en, no done, all outputs 0, ready=1; after release a new LW completes normally.
REQ-040 req held high for 6 cycles with SW then LW queued -> ready=0 between accepts, exactly one done per access, no overlap of strobes.
